// File: rtl/rf_pkg.sv
// -----------------------------------------------------------------------------
// rf_pkg
// Shared defaults and typedefs for the scoreboarded register file.
//   RF_DATA_W / RF_ADDR_W / RF_TAG_W : default widths used by the modules
//   NREG                             : register count at the default ADDR_W
//   reg_idx_t / rf_tag_t / rf_data_t : default-width index, tag and data types
// -----------------------------------------------------------------------------
package rf_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 4;
    localparam int RF_TAG_W  = 3;
    localparam int NREG      = 2 ** RF_ADDR_W;

    typedef logic [RF_ADDR_W-1:0] reg_idx_t;
    typedef logic [RF_TAG_W-1:0]  rf_tag_t;
    typedef logic [RF_DATA_W-1:0] rf_data_t;

endpackage : rf_pkg

// File: rtl/rf_read_port.sv
// -----------------------------------------------------------------------------
// rf_read_port
// One combinational read port of the register file: selects data, busy and
// tag for i_addr. With RF_WB_BYPASS_EN defined, a same-cycle writeback to the
// addressed register is forwarded, and busy shows its next-state value.
//
// Ports:
//   i_addr      read index
//   i_regs      register data array
//   i_busy      busy bit vector
//   i_tags      producer tag array
//   i_wb_en     writeback that will actually commit (register 0 already
//               excluded by the parent when it is hardwired)
//   i_wb_reg    writeback destination
//   i_wb_tag    writeback tag
//   i_wb_data   writeback data
//   i_alloc_en  allocate that will actually commit
//   i_alloc_reg allocate destination
//   o_data      read data
//   o_busy      register pending
//   o_tag       recorded producer tag
//
// Configuration macro: RF_WB_BYPASS_EN (same-cycle writeback forwarding).
// -----------------------------------------------------------------------------
module rf_read_port
    import rf_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int TAG_W  = RF_TAG_W
) (
    input  logic [ADDR_W-1:0]     i_addr,
    input  logic [DATA_W-1:0]     i_regs [2**ADDR_W],
    input  logic [2**ADDR_W-1:0]  i_busy,
    input  logic [TAG_W-1:0]      i_tags [2**ADDR_W],
    input  logic                  i_wb_en,
    input  logic [ADDR_W-1:0]     i_wb_reg,
    input  logic [TAG_W-1:0]      i_wb_tag,
    input  logic [DATA_W-1:0]     i_wb_data,
    input  logic                  i_alloc_en,
    input  logic [ADDR_W-1:0]     i_alloc_reg,
    output logic [DATA_W-1:0]     o_data,
    output logic                  o_busy,
    output logic [TAG_W-1:0]      o_tag
);

    assign o_tag = i_tags[i_addr];

`ifdef RF_WB_BYPASS_EN
    logic w_wb_hit;

    assign w_wb_hit = i_wb_en && (i_wb_reg == i_addr);

    // Busy reflects what the scoreboard will hold after this edge, so issue
    // logic can release a dependent instruction in the writeback cycle.
    assign o_data = w_wb_hit ? i_wb_data : i_regs[i_addr];
    assign o_busy = w_wb_hit
                  ? ((i_busy[i_addr] && (i_tags[i_addr] != i_wb_tag)) ||
                     (i_alloc_en && (i_alloc_reg == i_addr)))
                  : i_busy[i_addr];
`else
    // Forwarding inputs are only meaningful in the bypass build.
    logic w_unused;

    assign w_unused = ^{i_wb_en, i_wb_reg, i_wb_tag, i_wb_data,
                        i_alloc_en, i_alloc_reg};

    assign o_data = i_regs[i_addr];
    assign o_busy = i_busy[i_addr];
`endif

endmodule : rf_read_port

// File: rtl/reg_file_sb.sv
// -----------------------------------------------------------------------------
// reg_file_sb
// Parametrised register file with a tag-based scoreboard for decode/issue.
// Allocate marks a destination busy and records the producer tag; writeback
// always writes data but clears busy only when its tag matches the recorded
// one, so a stale producer never releases a newer reservation.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous reset, active-high
//   rd_addr    packed read indices, port i at [i*ADDR_W +: ADDR_W]
//   rd_data    read data per port
//   rd_busy    register pending per port
//   rd_tag     recorded producer tag per port
//   alloc_en   reserve alloc_reg for alloc_tag
//   alloc_reg  destination being issued
//   alloc_tag  tag of issuing instruction
//   wb_en      writeback valid
//   wb_reg     writeback destination
//   wb_tag     tag of completing instruction
//   wb_data    writeback result
//   flush      synchronous clear of all busy bits
//   busy_any   OR of all busy bits
//
// Configuration macro: RF_WB_BYPASS_EN (same-cycle writeback forwarding to
// the read ports, implemented in rf_read_port).
// -----------------------------------------------------------------------------
module reg_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = RF_DATA_W,
    parameter int ADDR_W   = RF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int TAG_W    = RF_TAG_W,
    parameter int ZERO_REG = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    output logic [NUM_RD*TAG_W-1:0]  rd_tag,
    input  logic                     alloc_en,
    input  logic [ADDR_W-1:0]        alloc_reg,
    input  logic [TAG_W-1:0]         alloc_tag,
    input  logic                     wb_en,
    input  logic [ADDR_W-1:0]        wb_reg,
    input  logic [TAG_W-1:0]         wb_tag,
    input  logic [DATA_W-1:0]        wb_data,
    input  logic                     flush,
    output logic                     busy_any
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_num_rd
        $error("reg_file_sb: NUM_RD must be in 1..4");
    end

    logic [DATA_W-1:0]   r_regs [NUM_REGS];
    logic [TAG_W-1:0]    r_tag  [NUM_REGS];
    logic [NUM_REGS-1:0] r_busy;

    logic                w_wb_we;
    logic                w_alloc_we;
    logic [NUM_REGS-1:0] w_busy_nxt;

    // With a hardwired zero register, register 0 is simply never written;
    // it stays at its reset value of data 0, busy 0, tag 0.
    assign w_wb_we    = wb_en    && !((ZERO_REG != 0) && (wb_reg    == '0));
    assign w_alloc_we = alloc_en && !((ZERO_REG != 0) && (alloc_reg == '0));

    // Priority, lowest first: flush, matching writeback, allocate. Allocate
    // last means the newest producer always owns the reservation.
    always_comb begin
        // NOTE: default assignment first so every path drives w_busy_nxt and no latch is inferred.
        w_busy_nxt = r_busy;
        if (flush) begin
            w_busy_nxt = '0;
        end
        if (w_wb_we && r_busy[wb_reg] && (r_tag[wb_reg] == wb_tag)) begin
            w_busy_nxt[wb_reg] = 1'b0;
        end
        if (w_alloc_we) begin
            w_busy_nxt[alloc_reg] = 1'b1;
        end
    end

    // NOTE: the storage array is reset explicitly because reads must return 0 immediately after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
                r_tag[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments so every state element updates from pre-edge values.
            r_busy <= w_busy_nxt;
            if (w_wb_we) begin
                r_regs[wb_reg] <= wb_data;
            end
            if (w_alloc_we) begin
                r_tag[alloc_reg] <= alloc_tag;
            end
        end
    end

    assign busy_any = |r_busy;

    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        rf_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .TAG_W  (TAG_W)
        ) u_rd (
            .i_addr      (rd_addr[g*ADDR_W +: ADDR_W]),
            .i_regs      (r_regs),
            .i_busy      (r_busy),
            .i_tags      (r_tag),
            .i_wb_en     (w_wb_we),
            .i_wb_reg    (wb_reg),
            .i_wb_tag    (wb_tag),
            .i_wb_data   (wb_data),
            .i_alloc_en  (w_alloc_we),
            .i_alloc_reg (alloc_reg),
            .o_data      (rd_data[g*DATA_W +: DATA_W]),
            .o_busy      (rd_busy[g]),
            .o_tag       (rd_tag[g*TAG_W +: TAG_W])
        );
    end

endmodule : reg_file_sb
